// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: write-back record, memory ops,
// FSM states and byte-enable constants.
package mem_stage_pkg;

  typedef logic reset_status_t;
  localparam reset_status_t RST_ENABLE = 1'b1;

  typedef logic [31:0] reg_data_t;
  typedef logic [4:0]  reg_addr_t;

  // Write-back record travelling EX -> MEM -> WB
  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } reg_t;

  typedef enum logic [3:0] {
    MEM_NONE,
    MEM_LB,
    MEM_LBU,
    MEM_LH,
    MEM_LHU,
    MEM_LW,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_t;

  typedef enum logic {
    IDLE,
    BUSY
  } mem_state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane logic: store byte enables and lane-replicated write
// data, load byte/half extraction with sign/zero extension, and alignment
// check for the current op.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  ea_lo_i,
  input  reg_data_t   sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output reg_data_t   ldata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{ea_lo_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{ea_lo_i[1], 4'b0000} +: 16];

  // Per-op lane selection, extension and alignment check
  always_comb begin
    be_o       = BE_NONE;
    wdata_o    = sdata_i;
    ldata_o    = rdata_i;
    misalign_o = 1'b0;
    case (op_i)
      MEM_SB: begin
        be_o    = BE_BYTE << ea_lo_i;
        wdata_o = {4{sdata_i[7:0]}};
      end
      MEM_SH: begin
        be_o       = ea_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o    = {2{sdata_i[15:0]}};
        misalign_o = ea_lo_i[0];
      end
      MEM_SW: begin
        be_o       = BE_WORD;
        misalign_o = |ea_lo_i;
      end
      MEM_LB: begin
        be_o    = BE_WORD;
        ldata_o = {{24{byte_sel[7]}}, byte_sel};
      end
      MEM_LBU: begin
        be_o    = BE_WORD;
        ldata_o = {24'h0, byte_sel};
      end
      MEM_LH: begin
        be_o       = BE_WORD;
        ldata_o    = {{16{half_sel[15]}}, half_sel};
        misalign_o = ea_lo_i[0];
      end
      MEM_LHU: begin
        be_o       = BE_WORD;
        ldata_o    = {16'h0, half_sel};
        misalign_o = ea_lo_i[0];
      end
      MEM_LW: begin
        be_o       = BE_WORD;
        misalign_o = |ea_lo_i;
      end
      default: begin
        be_o = BE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: accepts the EX record plus a memory op,
// runs at most one load/store on a req/ack data bus while stalling
// upstream, and emits a registered write-back record one cycle after
// completion. Non-memory ops pass through with one cycle of latency.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic          clk,
  input  reset_status_t rst,
  input  logic          mem_valid_i,
  input  reg_t          mem_wreg_i,
  input  mem_op_t       mem_op_i,
  input  reg_data_t     mem_sdata_i,
  output logic          mem_stall_o,
  output logic          dbus_req_o,
  output logic          dbus_we_o,
  output logic [31:0]   dbus_addr_o,
  output logic [3:0]    dbus_be_o,
  output logic [31:0]   dbus_wdata_o,
  input  logic          dbus_ack_i,
  input  logic [31:0]   dbus_rdata_i,
  output logic          mem_valid_o,
  output reg_t          mem_wreg_o,
  output logic          mem_except_o
);

  localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             valid_q, valid_d;
  logic             except_q, except_d;
  reg_t             wreg_out_q, wreg_out_d;

  // Op capture: only meaningful while BUSY, so left out of reset
  mem_op_t          op_q, op_d;
  logic [1:0]       ea_lo_q, ea_lo_d;
  reg_t             wreg_cap_q, wreg_cap_d;

  mem_op_t          align_op;
  logic [1:0]       align_ea_lo;
  logic [3:0]       align_be;
  logic [31:0]      align_wdata;
  reg_data_t        align_ldata;
  logic             align_misalign;
  logic             busy;

  assign busy = (state_q == BUSY);

  // While BUSY the lane logic extracts with the captured op; in IDLE it
  // qualifies the incoming op
  assign align_op    = busy ? op_q    : mem_op_i;
  assign align_ea_lo = busy ? ea_lo_q : mem_wreg_i.data[1:0];

  mem_stage_align u_align (
    .op_i       (align_op),
    .ea_lo_i    (align_ea_lo),
    .sdata_i    (mem_sdata_i),
    .rdata_i    (dbus_rdata_i),
    .be_o       (align_be),
    .wdata_o    (align_wdata),
    .ldata_o    (align_ldata),
    .misalign_o (align_misalign)
  );

  // Next-state, bus request and write-back record computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    valid_d    = 1'b0;
    except_d   = 1'b0;
    wreg_out_d = wreg_out_q;
    op_d       = op_q;
    ea_lo_d    = ea_lo_q;
    wreg_cap_d = wreg_cap_q;
    case (state_q)
      IDLE: begin
        if (mem_valid_i) begin
          cnt_d      = '0;
          op_d       = mem_op_i;
          ea_lo_d    = mem_wreg_i.data[1:0];
          wreg_cap_d = mem_wreg_i;
          if (mem_op_i == MEM_NONE) begin
            valid_d    = 1'b1;
            wreg_out_d = mem_wreg_i;
          end else if (align_misalign) begin
            valid_d       = 1'b1;
            except_d      = 1'b1;
            wreg_out_d    = mem_wreg_i;
            wreg_out_d.en = 1'b0;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = is_store(mem_op_i);
            addr_d  = {mem_wreg_i.data[31:2], 2'b00};
            be_d    = align_be;
            wdata_d = align_wdata;
          end
        end
      end
      BUSY: begin
        if (dbus_ack_i) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          valid_d    = 1'b1;
          wreg_out_d = wreg_cap_q;
          if (is_store(op_q)) begin
            wreg_out_d.en = 1'b0;
          end else begin
            wreg_out_d.data = align_ldata;
          end
        end else if ((BUS_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d       = IDLE;
          req_d         = 1'b0;
          valid_d       = 1'b1;
          except_d      = 1'b1;
          wreg_out_d    = wreg_cap_q;
          wreg_out_d.en = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM, counter and every registered output, cleared by reset
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      valid_q    <= 1'b0;
      except_q   <= 1'b0;
      wreg_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      except_q   <= except_d;
      wreg_out_q <= wreg_out_d;
    end
  end

  // Captured op details, consulted only after a bus access starts
  always_ff @(posedge clk) begin
    op_q       <= op_d;
    ea_lo_q    <= ea_lo_d;
    wreg_cap_q <= wreg_cap_d;
  end

  assign mem_stall_o  = busy;
  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;
  assign mem_valid_o  = valid_q;
  assign mem_wreg_o   = wreg_out_q;
  assign mem_except_o = except_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected write-back
// records, a bench-side bus responder, and one task per scenario.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic          clk = 1'b0;
  reset_status_t rst;
  logic          mem_valid_i;
  reg_t          mem_wreg_i;
  mem_op_t       mem_op_i;
  reg_data_t     mem_sdata_i;
  logic          mem_stall_o;
  logic          dbus_req_o;
  logic          dbus_we_o;
  logic [31:0]   dbus_addr_o;
  logic [3:0]    dbus_be_o;
  logic [31:0]   dbus_wdata_o;
  logic          dbus_ack_i;
  logic [31:0]   dbus_rdata_i;
  logic          mem_valid_o;
  reg_t          mem_wreg_o;
  logic          mem_except_o;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    reg_t wreg;
    logic except;
    logic chk_data;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we, obs_stall_at_valid;

  mem_stage #(.BUS_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid_i  (mem_valid_i),
    .mem_wreg_i   (mem_wreg_i),
    .mem_op_i     (mem_op_i),
    .mem_sdata_i  (mem_sdata_i),
    .mem_stall_o  (mem_stall_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_ack_i   (dbus_ack_i),
    .dbus_rdata_i (dbus_rdata_i),
    .mem_valid_o  (mem_valid_o),
    .mem_wreg_o   (mem_wreg_o),
    .mem_except_o (mem_except_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge. After the
  // accept cycle, wait for mem_valid_o while acking the bus once req has
  // been high for ack_wait cycles (ack_wait < 0: never ack).
  task automatic run_bus(input int ack_wait, input logic [31:0] rdata, input int budget,
                         output bit seen, output int lat, output int stall_cyc, output int req_cyc);
    seen = 1'b0; lat = 0; stall_cyc = 0; req_cyc = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      mem_valid_i  = 1'b0;
      dbus_ack_i   = 1'b0;
      dbus_rdata_i = 32'hDEADBEEF;
      if (mem_valid_o) begin
        seen = 1'b1;
        lat  = c + 1;
        obs_stall_at_valid = mem_stall_o;
      end else begin
        if (mem_stall_o) stall_cyc++;
        if (dbus_req_o) begin
          if (req_cyc == 0) begin
            obs_addr = dbus_addr_o; obs_be = dbus_be_o;
            obs_we = dbus_we_o; obs_wdata = dbus_wdata_o;
          end
          req_cyc++;
          if (ack_wait >= 0 && req_cyc > ack_wait) begin
            dbus_ack_i   = 1'b1;
            dbus_rdata_i = rdata;
          end
        end
      end
    end
  endtask

  task automatic drive_op(input mem_op_t op, input logic [4:0] rd, input logic [31:0] ea,
                          input logic [31:0] sdata);
    mem_valid_i = 1'b1;
    mem_op_i    = op;
    mem_wreg_i  = '{en: 1'b1, addr: rd, data: ea};
    mem_sdata_i = sdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({mem_valid_o, mem_except_o, mem_stall_o, dbus_req_o, dbus_we_o} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {mem_valid_o, mem_except_o, mem_stall_o, dbus_req_o, dbus_we_o});
    end
    tests_run++;
    if ({dbus_addr_o, dbus_be_o, dbus_wdata_o} !== 68'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr %h be %b wdata %h required 0", dbus_addr_o, dbus_be_o, dbus_wdata_o);
    end
    tests_run++;
    if (mem_wreg_o !== reg_t'(0)) begin
      tests_failed++;
      $display("FAIL reset_wreg: got %h required 0", mem_wreg_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    exp_t e;
    for (int i = 1; i <= 3; i++) begin
      drive_op(MEM_NONE, 5'(i + 3), 32'(i), 32'h0);
      exp_q.push_back('{wreg: '{en: 1'b1, addr: 5'(i + 3), data: 32'(i)}, except: 1'b0, chk_data: 1'b1});
      @(negedge clk);
      tests_run++;
      if (mem_stall_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL pass_stall[%0d]: got %b required 0", i, mem_stall_o);
      end
      e = exp_q.pop_front();
      tests_run++;
      if (mem_valid_o !== 1'b1 || mem_wreg_o !== e.wreg || mem_except_o !== e.except) begin
        tests_failed++;
        $display("FAIL pass_rec[%0d]: valid %b wreg %h exc %b required 1 %h %b",
                 i, mem_valid_o, mem_wreg_o, mem_except_o, e.wreg, e.except);
      end
    end
    mem_valid_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL pass_extra: valid %b required 0", mem_valid_o);
    end
  endtask

  task automatic test_store(input string nm, input mem_op_t op, input logic [31:0] ea,
                            input logic [31:0] sdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    bit seen; int lat, stall_cyc, req_cyc; exp_t e;
    drive_op(op, 5'd12, ea, sdata);
    exp_q.push_back('{wreg: '{en: 1'b0, addr: 5'd12, data: ea}, except: 1'b0, chk_data: 1'b0});
    run_bus(0, 32'h0, 10, seen, lat, stall_cyc, req_cyc);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || lat != 2 || mem_wreg_o.en !== e.wreg.en || mem_except_o !== e.except) begin
      tests_failed++;
      $display("FAIL %s_rec: seen %b lat %0d en %b exc %b required 1 2 %b %b",
               nm, seen, lat, mem_wreg_o.en, mem_except_o, e.wreg.en, e.except);
    end
    tests_run++;
    if (obs_addr !== {ea[31:2], 2'b00} || obs_be !== exp_be || obs_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_bus: addr %h be %b we %b required %h %b 1",
               nm, obs_addr, obs_be, obs_we, {ea[31:2], 2'b00}, exp_be);
    end
    tests_run++;
    if (obs_wdata !== exp_wdata) begin
      tests_failed++;
      $display("FAIL %s_wdata: got %h required %h", nm, obs_wdata, exp_wdata);
    end
  endtask

  task automatic test_load(input string nm, input mem_op_t op, input logic [4:0] rd,
                           input logic [31:0] ea, input int ack_wait,
                           input logic [31:0] rdata, input logic [31:0] exp_data);
    bit seen; int lat, stall_cyc, req_cyc; exp_t e;
    drive_op(op, rd, ea, 32'h0);
    exp_q.push_back('{wreg: '{en: 1'b1, addr: rd, data: exp_data}, except: 1'b0, chk_data: 1'b1});
    run_bus(ack_wait, rdata, 20, seen, lat, stall_cyc, req_cyc);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || mem_wreg_o !== e.wreg || mem_except_o !== e.except) begin
      tests_failed++;
      $display("FAIL %s_rec: seen %b wreg %h exc %b required 1 %h %b",
               nm, seen, mem_wreg_o, mem_except_o, e.wreg, e.except);
    end
    tests_run++;
    if (lat != ack_wait + 2 || stall_cyc != ack_wait + 1 || obs_stall_at_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_timing: lat %0d stall %0d stall_at_valid %b required %0d %0d 0",
               nm, lat, stall_cyc, obs_stall_at_valid, ack_wait + 2, ack_wait + 1);
    end
    tests_run++;
    if (obs_addr !== {ea[31:2], 2'b00} || obs_be !== 4'hF || obs_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_bus: addr %h be %b we %b required %h 1111 0",
               nm, obs_addr, obs_be, obs_we, {ea[31:2], 2'b00});
    end
  endtask

  task automatic test_misaligned(input string nm, input mem_op_t op, input logic [31:0] ea);
    bit seen; int lat, stall_cyc, req_cyc; exp_t e;
    drive_op(op, 5'd4, ea, 32'h11223344);
    exp_q.push_back('{wreg: '{en: 1'b0, addr: 5'd4, data: ea}, except: 1'b1, chk_data: 1'b0});
    run_bus(0, 32'h0, 6, seen, lat, stall_cyc, req_cyc);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || lat != 1 || mem_wreg_o.en !== e.wreg.en || mem_except_o !== e.except) begin
      tests_failed++;
      $display("FAIL %s_rec: seen %b lat %0d en %b exc %b required 1 1 %b %b",
               nm, seen, lat, mem_wreg_o.en, mem_except_o, e.wreg.en, e.except);
    end
    tests_run++;
    if (req_cyc != 0 || stall_cyc != 0) begin
      tests_failed++;
      $display("FAIL %s_nobus: req cycles %0d stall cycles %0d required 0 0", nm, req_cyc, stall_cyc);
    end
  endtask

  task automatic test_timeout();
    bit seen; int lat, stall_cyc, req_cyc; exp_t e;
    drive_op(MEM_LW, 5'd3, 32'h00004000, 32'h0);
    exp_q.push_back('{wreg: '{en: 1'b0, addr: 5'd3, data: 32'h4000}, except: 1'b1, chk_data: 1'b0});
    run_bus(-1, 32'h0, 12, seen, lat, stall_cyc, req_cyc);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || mem_wreg_o.en !== e.wreg.en || mem_except_o !== e.except) begin
      tests_failed++;
      $display("FAIL timeout_rec: seen %b en %b exc %b required 1 %b %b",
               seen, mem_wreg_o.en, mem_except_o, e.wreg.en, e.except);
    end
    tests_run++;
    if (req_cyc != 4 || lat != 5 || dbus_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_req: req cycles %0d lat %0d req %b required 4 5 0", req_cyc, lat, dbus_req_o);
    end
    // stray ack after the abort
    dbus_ack_i   = 1'b1;
    dbus_rdata_i = 32'h55555555;
    @(negedge clk);
    dbus_ack_i = 1'b0;
    tests_run++;
    if (mem_valid_o !== 1'b0 || mem_except_o !== 1'b0 || dbus_req_o !== 1'b0 || mem_stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stray_ack: valid %b exc %b req %b stall %b required 0 0 0 0",
               mem_valid_o, mem_except_o, dbus_req_o, mem_stall_o);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive_op(MEM_LHU, 5'd9, 32'h00006002, 32'h0);
    exp_q.push_back('{wreg: '{en: 1'b1, addr: 5'd9, data: 32'h00008001}, except: 1'b0, chk_data: 1'b1});
    @(negedge clk);
    // upstream now presents the next op and holds it while stalled
    drive_op(MEM_NONE, 5'd10, 32'h00005A5A, 32'h0);
    exp_q.push_back('{wreg: '{en: 1'b1, addr: 5'd10, data: 32'h00005A5A}, except: 1'b0, chk_data: 1'b1});
    @(negedge clk);
    tests_run++;
    if (mem_stall_o !== 1'b1 || mem_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_busy: stall %b valid %b required 1 0", mem_stall_o, mem_valid_o);
    end
    dbus_ack_i   = 1'b1;
    dbus_rdata_i = 32'h80010000;
    @(negedge clk);
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = 32'hDEADBEEF;
    e = exp_q.pop_front();
    tests_run++;
    if (mem_valid_o !== 1'b1 || mem_wreg_o !== e.wreg || mem_stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_load: valid %b wreg %h stall %b required 1 %h 0",
               mem_valid_o, mem_wreg_o, mem_stall_o, e.wreg);
    end
    @(negedge clk);
    mem_valid_i = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (mem_valid_o !== 1'b1 || mem_wreg_o !== e.wreg || mem_except_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_next: valid %b wreg %h exc %b required 1 %h 0",
               mem_valid_o, mem_wreg_o, mem_except_o, e.wreg);
    end
    @(negedge clk);
    tests_run++;
    if (mem_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_single: valid %b required 0", mem_valid_o);
    end
  endtask

  task automatic test_reset_busy();
    exp_t e;
    drive_op(MEM_LH, 5'd6, 32'h00007002, 32'h0);
    @(negedge clk);
    mem_valid_i = 1'b0;
    tests_run++;
    if (dbus_req_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstbusy_req: got %b required 1", dbus_req_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({mem_valid_o, mem_except_o, mem_stall_o, dbus_req_o, dbus_we_o} !== 5'b0 ||
        {dbus_addr_o, dbus_be_o, dbus_wdata_o} !== 68'h0 || mem_wreg_o !== reg_t'(0)) begin
      tests_failed++;
      $display("FAIL rstbusy_clear: ctrl %b addr %h be %b wdata %h wreg %h required all 0",
               {mem_valid_o, mem_except_o, mem_stall_o, dbus_req_o, dbus_we_o},
               dbus_addr_o, dbus_be_o, dbus_wdata_o, mem_wreg_o);
    end
    // late ack for the discarded load arrives alongside a fresh MEM_NONE
    dbus_ack_i   = 1'b1;
    dbus_rdata_i = 32'h7FFF0000;
    drive_op(MEM_NONE, 5'd2, 32'h000000C3, 32'h0);
    exp_q.push_back('{wreg: '{en: 1'b1, addr: 5'd2, data: 32'h000000C3}, except: 1'b0, chk_data: 1'b1});
    @(negedge clk);
    dbus_ack_i  = 1'b0;
    mem_valid_i = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (mem_valid_o !== 1'b1 || mem_wreg_o !== e.wreg || mem_except_o !== 1'b0 || dbus_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstbusy_next: valid %b wreg %h exc %b req %b required 1 %h 0 0",
               mem_valid_o, mem_wreg_o, mem_except_o, dbus_req_o, e.wreg);
    end
  endtask

  initial begin
    rst          = 1'b1;
    mem_valid_i  = 1'b0;
    mem_wreg_i   = '0;
    mem_op_i     = MEM_NONE;
    mem_sdata_i  = '0;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = 32'h0;
    test_reset();
    test_pass_through();
    test_store("sb", MEM_SB, 32'h00001003, 32'h123456AB, 4'b1000, 32'hABABABAB);
    test_store("sh", MEM_SH, 32'h00001002, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
    test_store("sw", MEM_SW, 32'h00001008, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    test_load("lb", MEM_LB, 5'd7, 32'h00002002, 3, 32'h00850000, 32'hFFFFFF85);
    test_load("lbu", MEM_LBU, 5'd7, 32'h00002002, 3, 32'h00850000, 32'h00000085);
    test_load("lh", MEM_LH, 5'd8, 32'h00002006, 1, 32'h9ABC1234, 32'hFFFF9ABC);
    test_load("lw_r0", MEM_LW, 5'd0, 32'h00003000, 0, 32'h12345678, 32'h12345678);
    test_misaligned("lw_mis", MEM_LW, 32'h00003002);
    test_misaligned("sh_mis", MEM_SH, 32'h00001001);
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
